display_scroller: RTL and testbench

DISPLAY_SCROLLER -- requirements
Module: display_scroller

---
 rtl/display_scroller.sv | 165 ++++++++++++++++
 tb/tb_display_scroller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scroller.sv
// Multiplexed 7-segment letter display: buffers up to BUF_DEPTH letter codes and
// scans NUM_DIGITS digits, optionally scrolling a NUM_DIGITS-wide window over the buffer.
module display_scroller #(
    parameter int NUM_DIGITS = 4,
    parameter int BUF_DEPTH  = 16,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [4:0]                     letter_in,
    input  logic                           letter_valid,
    output logic                           letter_ready,
    input  logic                           clear,
    input  logic                           scroll_en,
    output logic [6:0]                     seg,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int IW = AW + 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4:0]            letter_mem [BUF_DEPTH];

    logic [CW-1:0]         count_reg,  count_next;
    logic [IW-1:0]         offset_reg, offset_next;
    logic [DW-1:0]         digit_reg,  digit_next;
    logic [PW-1:0]         presc_reg,  presc_next;
    logic [FW-1:0]         frame_reg,  frame_next;
    logic [6:0]            seg_reg,    seg_next;
    logic [NUM_DIGITS-1:0] an_reg,     an_next;

    logic                  scan_wrap;
    logic                  frame_end;
    logic                  scroll_step;
    logic                  write_en;
    logic [IW-1:0]         span;
    logic [IW-1:0]         idx;

    function automatic logic [6:0] font(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'd0:  pat = 7'b1110111;
            5'd1:  pat = 7'b1111100;
            5'd2:  pat = 7'b1011000;
            5'd3:  pat = 7'b1011110;
            5'd4:  pat = 7'b1111001;
            5'd5:  pat = 7'b1110001;
            5'd6:  pat = 7'b1101111;
            5'd7:  pat = 7'b1110110;
            5'd8:  pat = 7'b0000110;
            5'd9:  pat = 7'b0011110;
            5'd10: pat = 7'b1111000;
            5'd11: pat = 7'b0111000;
            5'd12: pat = 7'b0010101;
            5'd13: pat = 7'b1010100;
            5'd14: pat = 7'b1011100;
            5'd15: pat = 7'b1110011;
            5'd16: pat = 7'b1100111;
            5'd17: pat = 7'b1010000;
            5'd18: pat = 7'b1101101;
            5'd19: pat = 7'b1000110;
            5'd20: pat = 7'b0111110;
            5'd21: pat = 7'b0011100;
            5'd22: pat = 7'b0101010;
            5'd23: pat = 7'b1001001;
            5'd24: pat = 7'b1101110;
            5'd25: pat = 7'b1011011;
            default: pat = 7'b1000000;
        endcase
        return pat;
    endfunction

    assign letter_ready = (count_reg < CW'(BUF_DEPTH));
    assign buf_count    = count_reg;
    assign seg          = seg_reg;
    assign an           = an_reg;

    assign scan_wrap   = (presc_reg == PW'(SCAN_DIV - 1));
    assign frame_end   = scan_wrap && (digit_reg == DW'(NUM_DIGITS - 1));
    assign scroll_step = frame_end && (frame_reg == FW'(SCROLL_DIV - 1));
    assign write_en    = letter_valid && letter_ready && !clear;
    // Largest legal offset; only meaningful while the buffer holds more than NUM_DIGITS letters.
    assign span        = IW'(count_reg) - IW'(NUM_DIGITS);

    always_comb begin
        presc_next  = scan_wrap ? '0 : presc_reg + 1'b1;
        digit_next  = digit_reg;
        frame_next  = frame_reg;
        count_next  = count_reg;
        offset_next = offset_reg;

        if (scan_wrap) begin
            digit_next = (digit_reg == DW'(NUM_DIGITS - 1)) ? '0 : digit_reg + 1'b1;
        end
        if (frame_end) begin
            frame_next = (frame_reg == FW'(SCROLL_DIV - 1)) ? '0 : frame_reg + 1'b1;
        end

        if (clear) begin
            count_next = '0;
        end else if (write_en) begin
            count_next = count_reg + 1'b1;
        end

        if (clear || !scroll_en) begin
            offset_next = '0;
        end else if (scroll_step) begin
            if (IW'(count_reg) > IW'(NUM_DIGITS)) begin
                offset_next = (offset_reg == span) ? '0 : offset_reg + 1'b1;
            end else begin
                offset_next = '0;
            end
        end
    end

    // Segments track the digit about to be enabled so an and seg always change together.
    assign idx = offset_next + IW'(digit_next);

    always_comb begin
        seg_next = 7'b0000000;
        if (idx < IW'(count_reg)) begin
            seg_next = font(letter_mem[idx[AW-1:0]]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
            assign an_next[gi] = (digit_next == DW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg  <= '0;
            offset_reg <= '0;
            digit_reg  <= '0;
            presc_reg  <= '0;
            frame_reg  <= '0;
            seg_reg    <= 7'b0000000;
            an_reg     <= NUM_DIGITS'(1);
        end else begin
            count_reg  <= count_next;
            offset_reg <= offset_next;
            digit_reg  <= digit_next;
            presc_reg  <= presc_next;
            frame_reg  <= frame_next;
            seg_reg    <= seg_next;
            an_reg     <= an_next;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            letter_mem[count_reg[AW-1:0]] <= letter_in;
        end
    end

endmodule

// File: tb/tb_display_scroller.sv
// Scoreboard bench for display_scroller: drivers push expected per-digit scan results,
// a negedge monitor pops and compares them once per digit slot.
module tb_display_scroller;

    localparam int ND = 4;
    localparam int BD = 8;
    localparam int SD = 4;
    localparam int SR = 2;
    localparam int CW = $clog2(BD + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [4:0]    letter_in = '0;
    logic          letter_valid = 1'b0;
    logic          clear = 1'b0;
    logic          scroll_en = 1'b0;
    logic          letter_ready;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [CW-1:0] buf_count;

    display_scroller #(
        .NUM_DIGITS (ND),
        .BUF_DEPTH  (BD),
        .SCAN_DIV   (SD),
        .SCROLL_DIV (SR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .letter_in    (letter_in),
        .letter_valid (letter_valid),
        .letter_ready (letter_ready),
        .clear        (clear),
        .scroll_en    (scroll_en),
        .seg          (seg),
        .an           (an),
        .buf_count    (buf_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_font(input logic [4:0] code);
        case (code)
            5'd0:  return 7'b1110111;
            5'd1:  return 7'b1111100;
            5'd2:  return 7'b1011000;
            5'd3:  return 7'b1011110;
            5'd4:  return 7'b1111001;
            5'd5:  return 7'b1110001;
            5'd6:  return 7'b1101111;
            5'd7:  return 7'b1110110;
            5'd8:  return 7'b0000110;
            5'd9:  return 7'b0011110;
            5'd10: return 7'b1111000;
            5'd11: return 7'b0111000;
            5'd12: return 7'b0010101;
            5'd13: return 7'b1010100;
            5'd14: return 7'b1011100;
            5'd15: return 7'b1110011;
            5'd16: return 7'b1100111;
            5'd17: return 7'b1010000;
            5'd18: return 7'b1101101;
            5'd19: return 7'b1000110;
            5'd20: return 7'b0111110;
            5'd21: return 7'b0011100;
            5'd22: return 7'b0101010;
            5'd23: return 7'b1001001;
            5'd24: return 7'b1101110;
            5'd25: return 7'b1011011;
            default: return 7'b1000000;
        endcase
    endfunction

    // Reference model of the buffer and the scroll window
    logic [4:0]    m_mem [BD];
    int            m_count = 0;
    int            m_offset = 0;
    logic [ND-1:0] q_an [$];
    logic [6:0]    q_seg [$];

    int            slot_len = 0;
    int            slot_k = 0;
    int            frame_ends = 0;
    bit            period_ok = 1'b0;
    bit            frame_start = 1'b0;
    logic [ND-1:0] an_prev = 4'b0001;
    logic [ND-1:0] e_an;
    logic [6:0]    e_seg;

    always @(negedge clk) begin
        if (!reset_n) begin
            slot_len    = 0;
            slot_k      = 0;
            frame_ends  = 0;
            period_ok   = 1'b0;
            frame_start = 1'b0;
            an_prev     = 4'b0001;
            m_offset    = 0;
        end else begin
            frame_start = 1'b0;
            slot_len++;
            if (an !== an_prev) begin
                if (period_ok) check_eq("scan_period", slot_len, SD);
                period_ok = 1'b1;
                slot_len  = 0;
                slot_k    = 0;
                if (an_prev == 4'b1000 && an == 4'b0001) begin
                    frame_ends++;
                    frame_start = 1'b1;
                    if ((frame_ends % SR) == 0 && scroll_en && m_count > ND)
                        m_offset = (m_offset == m_count - ND) ? 0 : m_offset + 1;
                end
            end else begin
                slot_k++;
            end
            an_prev = an;
            if (!scroll_en || m_count <= ND) m_offset = 0;
            if (slot_k == 1 && q_an.size() > 0) begin
                e_an  = q_an.pop_front();
                e_seg = q_seg.pop_front();
                check_eq("scan_an", an, e_an);
                check_eq("scan_seg", seg, e_seg);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_letter(input logic [4:0] code);
        letter_in    = code;
        letter_valid = 1'b1;
        tick();
        if (m_count < BD) begin
            m_mem[m_count] = code;
            m_count++;
            $display("write code %0d accepted, count %0d", code, m_count);
        end else begin
            $display("write code %0d dropped, buffer full", code);
        end
    endtask

    task automatic end_writes();
        letter_valid = 1'b0;
    endtask

    task automatic do_clear(input bit with_valid);
        clear        = 1'b1;
        letter_valid = with_valid;
        letter_in    = 5'd7;
        tick();
        clear        = 1'b0;
        letter_valid = 1'b0;
        m_count      = 0;
        $display("clear (valid=%0d)", with_valid);
    endtask

    task automatic wait_frame_start();
        for (int i = 0; i < 64; i++) begin
            tick();
            if (frame_start) return;
        end
        check_eq("frame_timeout", 0, 1);
    endtask

    task automatic expect_frames(input int n);
        int idx;
        for (int f = 0; f < n; f++) begin
            wait_frame_start();
            for (int k = 0; k < ND; k++) begin
                idx = m_offset + k;
                q_an.push_back(4'(1 << k));
                q_seg.push_back((idx < m_count) ? exp_font(m_mem[idx]) : 7'b0000000);
            end
            $display("frame expected: offset %0d count %0d", m_offset, m_count);
        end
        for (int i = 0; i < 64; i++) begin
            if (q_an.size() == 0) break;
            tick();
        end
        if (q_an.size() != 0) begin
            check_eq("drain_timeout", q_an.size(), 0);
            q_an.delete();
            q_seg.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_an", an, 4'b0001);
        check_eq("rst_seg", seg, 7'b0000000);
        check_eq("rst_ready", letter_ready, 1'b1);
        check_eq("rst_count", buf_count, 0);
        #2 reset_n = 1'b1;
        tick();

        // Empty buffer: blank digits, an rotating
        expect_frames(2);

        // Static a, b, c
        write_letter(5'd0);
        write_letter(5'd1);
        write_letter(5'd2);
        end_writes();
        check_eq("count_abc", buf_count, 3);
        check_eq("ready_abc", letter_ready, 1'b1);
        expect_frames(2);

        // Six letters, scrolling window
        write_letter(5'd3);
        write_letter(5'd4);
        write_letter(5'd5);
        end_writes();
        wait_frame_start();
        scroll_en = 1'b1;
        expect_frames(9);
        scroll_en = 1'b0;
        tick();
        expect_frames(1);

        // Nine back-to-back writes into an eight-entry buffer
        do_clear(1'b0);
        for (int i = 0; i < 9; i++) begin
            write_letter(5'(10 + i));
            if (i == 7) begin
                check_eq("count_at_full", buf_count, 8);
                check_eq("ready_at_full", letter_ready, 1'b0);
            end
        end
        end_writes();
        check_eq("count_full_hold", buf_count, 8);
        check_eq("ready_full_hold", letter_ready, 1'b0);
        wait_frame_start();
        scroll_en = 1'b1;
        expect_frames(10);
        scroll_en = 1'b0;
        tick();

        // Clear wins over a simultaneous write
        do_clear(1'b0);
        for (int i = 0; i < 5; i++) write_letter(5'(20 + i));
        end_writes();
        check_eq("count_five", buf_count, 5);
        do_clear(1'b1);
        check_eq("clr_count", buf_count, 0);
        check_eq("clr_ready", letter_ready, 1'b1);
        tick();
        check_eq("clr_blank", seg, 7'b0000000);
        expect_frames(1);

        // Invalid code shows a dash, then reset mid-frame
        write_letter(5'd27);
        end_writes();
        expect_frames(1);
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst2_an", an, 4'b0001);
        check_eq("rst2_seg", seg, 7'b0000000);
        check_eq("rst2_count", buf_count, 0);
        check_eq("rst2_ready", letter_ready, 1'b1);
        m_count = 0;
        repeat (2) tick();
        #2 reset_n = 1'b1;
        write_letter(5'd4);
        end_writes();
        check_eq("post_rst_count", buf_count, 1);
        expect_frames(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
